exec_stage: RTL

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_stage.sv | 104 ++++++++++
 1 files changed

// File: rtl/exec_stage.sv
// Purpose: ALU execute stage with registered result/flags and a one-entry EMPTY/FULL output buffer.
// Latency: 1 cycle from accepted operand set to c_out/status; full throughput when out_ready stays high.
// Backpressure: in_ready = EMPTY | out_ready, so a stalled FULL stage holds its result and ignores inputs.
// Option: define EXEC_STAGE_OVF_EN to drive status[1] (V) with signed overflow; otherwise V is tied to 0.
module exec_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a_in,
    input  logic [15:0] b_shifted,
    input  logic [15:0] sximm5,
    input  logic        asel,
    input  logic        bsel,
    input  logic [1:0]  aluop,
    input  logic        loads,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] c_out,
    output logic [2:0]  status
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_accept;
    logic [15:0] w_ain;
    logic [15:0] w_bin;
    logic [15:0] w_result;
    logic        w_ovf;
    logic [15:0] r_c_out;
    logic [2:0]  r_status;

    // ALU operand muxing and function select
    always_comb begin
        w_ain    = asel ? 16'h0000 : a_in;
        w_bin    = bsel ? sximm5 : b_shifted;
        w_result = 16'h0000;
        case (aluop)
            OP_ADD:  w_result = w_ain + w_bin;
            OP_SUB:  w_result = w_ain - w_bin;
            OP_AND:  w_result = w_ain & w_bin;
            OP_NOT:  w_result = ~w_bin;
            default: w_result = 16'h0000;
        endcase
    end

`ifdef EXEC_STAGE_OVF_EN
    // Signed overflow: operand signs agree (ADD) or differ (SUB) and the result sign flips away from A
    always_comb begin
        w_ovf = 1'b0;
        case (aluop)
            OP_ADD:  w_ovf = (w_ain[15] == w_bin[15]) && (w_result[15] != w_ain[15]);
            OP_SUB:  w_ovf = (w_ain[15] != w_bin[15]) && (w_result[15] != w_ain[15]);
            default: w_ovf = 1'b0;
        endcase
    end
`else
    assign w_ovf = 1'b0;
`endif

    // Handshake and next-state: a FULL stage frees itself only when downstream consumes
    always_comb begin
        in_ready     = (r_state == EMPTY) || out_ready;
        w_accept     = in_valid && in_ready;
        w_next_state = r_state;
        case (r_state)
            EMPTY: if (w_accept) w_next_state = FULL;
            FULL:  if (out_ready) w_next_state = w_accept ? FULL : EMPTY;
            default: w_next_state = EMPTY;
        endcase
    end

    // State register; reset wins over any same-cycle accept
    always_ff @(posedge clk) begin
        if (reset) r_state <= EMPTY;
        else       r_state <= w_next_state;
    end

    // Result and flag registers load only on accept; flags additionally gated by loads
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_out  <= 16'h0000;
            r_status <= 3'b000;
        end else if (w_accept) begin
            r_c_out <= w_result;
            if (loads) r_status <= {w_result[15], w_ovf, (w_result == 16'h0000)};
        end
    end

    assign out_valid = (r_state == FULL);
    assign c_out     = r_c_out;
    assign status    = r_status;

endmodule
